// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// fifo_sync_flags : show-ahead synchronous FIFO with occupancy count,
//                   almost-full/almost-empty thresholds and sticky errors
// Revision 1.0
// ============================================================================
module fifo_sync_flags #(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 4,
  parameter int AF_LEVEL = 2**A_WIDTH-2,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               rd,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               flush,
  input  logic               clr_err,
  output logic [D_WIDTH-1:0] r_data,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic [A_WIDTH:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int             DEPTH   = 2**A_WIDTH;
  localparam logic [A_WIDTH:0]   C_DEPTH = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH:0]   C_CNT1  = (A_WIDTH+1)'(1);
  localparam logic [A_WIDTH-1:0] C_PTR1  = A_WIDTH'(1);
  localparam logic           C_AE_RST = (AE_LEVEL >= 0);
  localparam logic           C_AF_RST = (AF_LEVEL <= 0);

  logic [D_WIDTH-1:0] buff_q [DEPTH];
  logic [A_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [A_WIDTH:0]   count_q, count_d;
  logic empty_q, empty_d, full_q, full_d;
  logic almost_empty_q, almost_empty_d, almost_full_q, almost_full_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic w_rd_ok, w_wr_ok, w_mem_we;

  assign w_rd_ok  = rd & ~empty_q;
  assign w_wr_ok  = wr & (~full_q | rd);
  assign w_mem_we = rst & ~flush & w_wr_ok;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      // A new error on the same edge as clr_err keeps the flag set.
      if (wr & ~w_wr_ok) overflow_d  = 1'b1;
      if (rd & ~w_rd_ok) underflow_d = 1'b1;
      if (w_wr_ok) w_ptr_d = w_ptr_q + C_PTR1;
      if (w_rd_ok) r_ptr_d = r_ptr_q + C_PTR1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   count_d = count_q + C_CNT1;
        2'b01:   count_d = count_q - C_CNT1;
        default: count_d = count_q;
      endcase
    end
    empty_d        = (count_d == '0);
    full_d         = (count_d == C_DEPTH);
    almost_empty_d = (int'(count_d) <= AE_LEVEL);
    almost_full_d  = (int'(count_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q        <= '0;
      r_ptr_q        <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= C_AE_RST;
      almost_full_q  <= C_AF_RST;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      w_ptr_q        <= w_ptr_d;
      r_ptr_q        <= r_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) buff_q[w_ptr_q] <= w_data;
  end

  assign r_data       = buff_q[r_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// tb_fifo_sync_flags : directed scoreboard bench for fifo_sync_flags
// Revision 1.0
// ============================================================================
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst, wr, rd, flush, clr_err;
  logic [7:0] w_data, r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic       m_over = 1'b0;
  logic       m_under = 1'b0;

  fifo_sync_flags #(.D_WIDTH(8), .A_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .w_data(w_data), .flush(flush),
    .clr_err(clr_err), .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = m_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 4));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
    chk("almost_full", 32'(almost_full), 32'(n >= 3));
    chk("overflow", 32'(overflow), 32'(m_over));
    chk("underflow", 32'(underflow), 32'(m_under));
    if (n > 0) chk("head", 32'(r_data), 32'(m_q[0]));
  endtask

  // One clock: drive at negedge, check popped data before the edge, state after.
  task automatic step(input logic s_wr, input logic s_rd, input logic [7:0] s_d,
                      input logic s_fl, input logic s_clr);
    bit rd_ok, wr_ok;
    logic [7:0] e;
    wr = s_wr; rd = s_rd; w_data = s_d; flush = s_fl; clr_err = s_clr;
    rd_ok = s_rd && (m_q.size() > 0);
    wr_ok = s_wr && ((m_q.size() < 4) || s_rd);
    m_over  = m_over  && !s_clr;
    m_under = m_under && !s_clr;
    if (s_fl) begin
      m_q.delete();
    end else begin
      if (rd_ok) begin
        e = m_q.pop_front();
        chk("rd_data", 32'(r_data), 32'(e));
      end
      if (wr_ok) m_q.push_back(s_d);
      if (s_wr && !wr_ok) m_over = 1'b1;
      if (s_rd && !rd_ok) m_under = 1'b1;
    end
    @(posedge clk); #1;
    chk_state();
    @(negedge clk);
    wr = 0; rd = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    rst = 1'b0; wr = 0; rd = 0; flush = 0; clr_err = 0; w_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 8'h00, 0, 0);

    // Fill, overflow, drain
    step(1, 0, 8'hA1, 0, 0);
    chk("first_count", 32'(count), 32'd1);
    chk("first_head", 32'(r_data), 32'hA1);
    step(1, 0, 8'hB2, 0, 0);
    step(1, 0, 8'hC3, 0, 0);
    chk("af_at_3", 32'(almost_full), 32'd1);
    step(1, 0, 8'hD4, 0, 0);
    chk("full_at_4", 32'(full), 32'd1);
    step(1, 0, 8'hE5, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    repeat (4) step(0, 1, 8'h00, 0, 0);
    chk("drained", 32'(empty), 32'd1);

    // Full with simultaneous read and write
    step(1, 0, 8'hA1, 0, 0);
    step(1, 0, 8'hB2, 0, 0);
    step(1, 0, 8'hC3, 0, 0);
    step(1, 0, 8'hD4, 0, 0);
    step(1, 1, 8'h55, 0, 0);
    chk("rw_full_head", 32'(r_data), 32'hB2);
    repeat (4) step(0, 1, 8'h00, 0, 0);

    // Empty with simultaneous read and write
    step(1, 1, 8'h77, 0, 0);
    chk("rw_empty_udf", 32'(underflow), 32'd1);
    chk("rw_empty_head", 32'(r_data), 32'h77);
    step(0, 0, 8'h00, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    step(0, 1, 8'h00, 0, 0);
    // clr_err together with a fresh error keeps the flag
    step(0, 1, 8'h00, 0, 1);
    chk("clr_vs_new", 32'(underflow), 32'd1);

    // Wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'(i), 0, 0);
      step(0, 1, 8'h00, 0, 0);
    end

    // Flush with pending rd/wr
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 1, 8'h44, 1, 0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_udf_kept", 32'(underflow), 32'd1);
    step(1, 0, 8'h66, 0, 1);
    chk("post_flush_head", 32'(r_data), 32'h66);

    // Asynchronous reset mid-stream
    step(1, 0, 8'h99, 0, 0);
    #2 rst = 1'b0;
    #1;
    m_q.delete(); m_over = 1'b0; m_under = 1'b0;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h5A, 0, 0);
    step(0, 1, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parameterised synchronous show-ahead FIFO for the PS/2 and UART receive/transmit paths.
- Adds the following over the basic FIFO:
  - occupancy count
  - compile-time almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags with a clear input
  - synchronous flush
- Single clock domain, sitting between a byte producer (e.g. the PS/2 receiver) and its consumer.

Parameters:
- D_WIDTH, 8: data width in bits.
- A_WIDTH, 4: address width; depth DEPTH = 2**A_WIDTH. Must be at least 1.
- AF_LEVEL, 2**A_WIDTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- wr  input  1  write request.
- rd  input  1  read request; pops the current head.
- w_data  input  D_WIDTH  write data.
- flush  input  1  synchronous clear of contents.
- clr_err  input  1  synchronous clear of the sticky error flags.
- r_data  output  D_WIDTH  head entry, show-ahead.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  A_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset:
  - rst low immediately forces w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), overflow=0, underflow=0.
  - Buffer contents are not reset; r_data is don't-care while empty.
  - Release of rst is synchronous-safe: no accept occurs on the edge where rst rises.
- Storage and pointers:
  - Storage is a DEPTH x D_WIDTH register array, written on the clk edge at w_ptr.
  - r_data = buff[r_ptr] combinationally, so the head is valid while empty=0 with zero read latency.
  - Pointers are A_WIDTH bits and wrap modulo DEPTH.
  - count is a separate A_WIDTH+1 bit register.
  - All flags are registered and derived from the next count, so they change on the same edge as count.
- Acceptance, evaluated on each rising edge:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd).
  - When full, a simultaneous rd and wr both succeed and count is unchanged.
  - When empty, a simultaneous rd and wr accepts the write only. The read is rejected, underflow is set, and count becomes 1.
- Update on accept:
  - rd_ok: r_ptr+1.
  - wr_ok: write buff[w_ptr], w_ptr+1.
  - count += wr_ok - rd_ok.
- Errors:
  - wr & ~wr_ok sets overflow; the data is dropped and the pointers are untouched.
  - rd & ~rd_ok sets underflow.
  - Both flags hold until clr_err or reset.
  - If clr_err and a new error occur on the same edge, the new error wins (the flag stays 1).
- flush:
  - Sets pointers and count to 0 on the edge and ignores wr and rd that cycle.
  - Error flags are unaffected.
  - flush has priority over wr and rd.
- Thresholds:
  - Flags are compared against count.
  - AE_LEVEL >= DEPTH keeps almost_empty permanently 1.
  - AF_LEVEL = 0 keeps almost_full permanently 1. These settings are legal, not errors.
- Invariants:
  - count never exceeds DEPTH.
  - (w_ptr - r_ptr) mod DEPTH == count mod DEPTH.
  - full and empty are never both 1.
- Reset asserted mid-operation discards all contents at once, with no further outputs from the old data.

Test Plan:
- D_WIDTH=8, A_WIDTH=2 (DEPTH=4), AF_LEVEL=3, AE_LEVEL=1 unless stated.
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, overflow=underflow=0.
- Write 0xA1,0xB2,0xC3,0xD4 on consecutive cycles:
  - after edge 1: count=1 and r_data=0xA1.
  - almost_full=1 after the third write.
  - full=1 and count=4 after the fourth write.
  - a fifth write of 0xE5 -> overflow=1, count stays 4, and reads return A1,B2,C3,D4 in order, ending with empty=1.
- Full FIFO, simultaneous rd and wr of 0x55 -> count stays 4, r_data moves to 0xB2. After 4 further reads the sequence is B2,C3,D4,55.
- Empty FIFO, rd with wr of 0x77 -> underflow=1, count=1, r_data=0x77.
- clr_err asserted alone -> overflow=underflow=0 next edge.
- Wrap-around: 10 write/read pairs on alternating cycles with data 0..9 -> every read matches the write order, and count stays in 0..1 throughout.
- Flush with count=3 plus rd/wr asserted -> count=0, empty=1, pointers 0, error flags unchanged.
- rst pulsed low mid-stream with count=2 -> count=0 and empty=1 immediately, without waiting for a clk edge.
